// File: rtl/rob.sv
// Reorder buffer: allocates rename tags at issue, captures writeback results,
// retires entries in program order and answers register-file tag queries.
// Tag 0 is reserved as "no entry"; pointers cycle 1..2^W-1.
module rob #(
  parameter int unsigned ROB_SIZE_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      issue_valid,
  input  logic [4:0]                issue_dest,
  output logic                      rob_full,
  output logic [ROB_SIZE_WIDTH-1:0] issue_rob_id,
  output logic [4:0]                issue_rd,
  input  logic                      wb_valid,
  input  logic [ROB_SIZE_WIDTH-1:0] wb_rob_id,
  input  logic [31:0]               wb_value,
  input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id1,
  input  logic [ROB_SIZE_WIDTH-1:0] ask_rob_id2,
  output logic [31:0]               get_value1,
  output logic [31:0]               get_value2,
  output logic                      get_ready1,
  output logic                      get_ready2,
  output logic [ROB_SIZE_WIDTH-1:0] commit_rob_id,
  output logic [4:0]                commit_rd,
  output logic [31:0]               commit_value,
  input  logic                      flush
);

  localparam int unsigned W       = ROB_SIZE_WIDTH;
  localparam int unsigned NE      = 1 << W;
  localparam logic [W-1:0] TAG_MAX = W'(NE - 1);
  localparam logic [W-1:0] TAG_ONE = W'(1);

  logic [NE-1:0] busy_q, busy_d;
  logic [NE-1:0] ready_q, ready_d;
  logic [4:0]    rd_q    [NE];
  logic [4:0]    rd_d    [NE];
  logic [31:0]   value_q [NE];
  logic [31:0]   value_d [NE];
  logic [W-1:0]  head_q, head_d;
  logic [W-1:0]  tail_q, tail_d;
  logic [W-1:0]  count_q, count_d;
  logic          rob_full_q, rob_full_d;
  logic [W-1:0]  commit_id_q, commit_id_d;
  logic [4:0]    commit_rd_q, commit_rd_d;
  logic [31:0]   commit_value_q, commit_value_d;
  logic          acc;
  logic          wb_en;
  logic          cmt;

  // Pointer advance skipping the reserved tag 0.
  function automatic logic [W-1:0] ptr_inc(input logic [W-1:0] p);
    return (p == TAG_MAX) ? TAG_ONE : p + TAG_ONE;
  endfunction

  // Next-state: writeback, allocate, retire, then flush overrides everything.
  always_comb begin
    busy_d         = busy_q;
    ready_d        = ready_q;
    rd_d           = rd_q;
    value_d        = value_q;
    head_d         = head_q;
    tail_d         = tail_q;
    commit_id_d    = '0;
    commit_rd_d    = '0;
    commit_value_d = '0;

    acc   = rdy & issue_valid & ~rob_full_q & ~flush;
    wb_en = rdy & wb_valid & ~flush & (wb_rob_id != '0) & busy_q[wb_rob_id];
    cmt   = rdy & ~flush & busy_q[head_q] & ready_q[head_q];

    if (wb_en) begin
      ready_d[wb_rob_id] = 1'b1;
      value_d[wb_rob_id] = wb_value;
    end

    if (acc) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      rd_d[tail_q]    = issue_dest;
      tail_d          = ptr_inc(tail_q);
    end

    if (cmt) begin
      busy_d[head_q]  = 1'b0;
      ready_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
      commit_value_d  = value_q[head_q];
      if (rd_q[head_q] != 5'd0) begin
        commit_id_d = head_q;
        commit_rd_d = rd_q[head_q];
      end
    end

    count_d = count_q + W'(acc) - W'(cmt);

    if (rdy & flush) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = TAG_ONE;
      tail_d  = TAG_ONE;
      count_d = '0;
    end

    rob_full_d = (count_d == TAG_MAX);
  end

  // State registers; commit pulse regs clear whenever nothing retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q         <= '0;
      ready_q        <= '0;
      for (int unsigned i = 0; i < NE; i++) begin
        rd_q[i]    <= '0;
        value_q[i] <= '0;
      end
      head_q         <= TAG_ONE;
      tail_q         <= TAG_ONE;
      count_q        <= '0;
      rob_full_q     <= 1'b0;
      commit_id_q    <= '0;
      commit_rd_q    <= '0;
      commit_value_q <= '0;
    end else begin
      busy_q         <= busy_d;
      ready_q        <= ready_d;
      rd_q           <= rd_d;
      value_q        <= value_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      rob_full_q     <= rob_full_d;
      commit_id_q    <= commit_id_d;
      commit_rd_q    <= commit_rd_d;
      commit_value_q <= commit_value_d;
    end
  end

  // Tag queries with same-cycle writeback forwarding.
  always_comb begin
    get_ready1 = 1'b0;
    get_value1 = '0;
    get_ready2 = 1'b0;
    get_value2 = '0;
    if ((ask_rob_id1 != '0) && busy_q[ask_rob_id1]) begin
      if (wb_valid && (wb_rob_id == ask_rob_id1)) begin
        get_ready1 = 1'b1;
        get_value1 = wb_value;
      end else begin
        get_ready1 = ready_q[ask_rob_id1];
        get_value1 = value_q[ask_rob_id1];
      end
    end
    if ((ask_rob_id2 != '0) && busy_q[ask_rob_id2]) begin
      if (wb_valid && (wb_rob_id == ask_rob_id2)) begin
        get_ready2 = 1'b1;
        get_value2 = wb_value;
      end else begin
        get_ready2 = ready_q[ask_rob_id2];
        get_value2 = value_q[ask_rob_id2];
      end
    end
  end

  assign issue_rob_id  = acc ? tail_q : '0;
  assign issue_rd      = acc ? issue_dest : 5'd0;
  assign rob_full      = rob_full_q;
  assign commit_rob_id = commit_id_q;
  assign commit_rd     = commit_rd_q;
  assign commit_value  = commit_value_q;

endmodule

// File: tb/tb_rob.sv
// Randomized self-checking bench for rob against a queue-based program-order model.
module tb_rob;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        issue_valid;
  logic [4:0]  issue_dest;
  logic        rob_full;
  logic [2:0]  issue_rob_id;
  logic [4:0]  issue_rd;
  logic        wb_valid;
  logic [2:0]  wb_rob_id;
  logic [31:0] wb_value;
  logic [2:0]  ask_rob_id1, ask_rob_id2;
  logic [31:0] get_value1, get_value2;
  logic        get_ready1, get_ready2;
  logic [2:0]  commit_rob_id;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic        flush;

  rob #(.ROB_SIZE_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .rob_full(rob_full), .issue_rob_id(issue_rob_id), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .ask_rob_id1(ask_rob_id1), .ask_rob_id2(ask_rob_id2),
    .get_value1(get_value1), .get_value2(get_value2),
    .get_ready1(get_ready1), .get_ready2(get_ready2),
    .commit_rob_id(commit_rob_id), .commit_rd(commit_rd), .commit_value(commit_value),
    .flush(flush)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: in-flight instructions in program order.
  typedef struct {
    logic [2:0] tag;
    logic [4:0] rd;
    logic       rdy;
  } ent_t;

  ent_t        rob_m[$];
  logic [31:0] mval[8];
  int          next_tag;
  logic        full_m;
  logic [2:0]  cm_id;
  logic [4:0]  cm_rd;
  logic [31:0] cm_val;
  logic        cm_silent;

  logic [2:0]  obs_issue_id;
  logic [4:0]  obs_issue_rd;
  logic        obs_gr1, obs_gr2, obs_full;
  logic [31:0] obs_gv1, obs_gv2;
  logic [2:0]  obs_cm_id;
  logic [4:0]  obs_cm_rd;
  logic [31:0] obs_cm_val;
  logic [2:0]  seen[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int find(input logic [2:0] t);
    for (int i = 0; i < rob_m.size(); i++)
      if (rob_m[i].tag == t) return i;
    return -1;
  endfunction

  task automatic model_reset();
    rob_m.delete();
    for (int i = 0; i < 8; i++) mval[i] = 32'h0;
    next_tag  = 1;
    full_m    = 1'b0;
    cm_id     = '0;
    cm_rd     = '0;
    cm_val    = '0;
    cm_silent = 1'b0;
  endtask

  task automatic q_exp(input logic [2:0] q, input logic wv, input logic [2:0] wid,
                       input logic [31:0] wval, output logic rr, output logic [31:0] vv);
    int k;
    k  = find(q);
    rr = 1'b0;
    vv = 32'h0;
    if (q != 3'd0 && k >= 0) begin
      if (wv && wid == q) begin
        rr = 1'b1;
        vv = wval;
      end else begin
        rr = rob_m[k].rdy;
        vv = mval[q];
      end
    end
  endtask

  // One clock cycle: drive at negedge, check, advance model at posedge.
  task automatic cyc(input logic r, input logic iv, input logic [4:0] d,
                     input logic wv, input logic [2:0] wid, input logic [31:0] wval,
                     input logic [2:0] q1, input logic [2:0] q2, input logic fl);
    logic        acc, er, do_cmt;
    logic [31:0] ev;
    int          k;
    rdy = r; issue_valid = iv; issue_dest = d;
    wb_valid = wv; wb_rob_id = wid; wb_value = wval;
    ask_rob_id1 = q1; ask_rob_id2 = q2; flush = fl;
    #1;
    acc = r & iv & ~full_m & ~fl;
    check_eq("issue_rob_id", 32'(issue_rob_id), acc ? 32'(next_tag) : 32'h0);
    check_eq("issue_rd", 32'(issue_rd), acc ? 32'(d) : 32'h0);
    q_exp(q1, wv, wid, wval, er, ev);
    check_eq("get_ready1", 32'(get_ready1), 32'(er));
    check_eq("get_value1", get_value1, ev);
    q_exp(q2, wv, wid, wval, er, ev);
    check_eq("get_ready2", 32'(get_ready2), 32'(er));
    check_eq("get_value2", get_value2, ev);
    check_eq("rob_full", 32'(rob_full), 32'(full_m));
    check_eq("commit_rob_id", 32'(commit_rob_id), 32'(cm_id));
    check_eq("commit_rd", 32'(commit_rd), 32'(cm_rd));
    if (!cm_silent) check_eq("commit_value", commit_value, cm_val);
    obs_issue_id = issue_rob_id; obs_issue_rd = issue_rd;
    obs_gr1 = get_ready1; obs_gv1 = get_value1;
    obs_gr2 = get_ready2; obs_gv2 = get_value2;
    obs_full = rob_full;
    obs_cm_id = commit_rob_id; obs_cm_rd = commit_rd; obs_cm_val = commit_value;
    seen.push_back(commit_rob_id);
    @(posedge clk);
    if (!r) begin
      cm_id = '0; cm_rd = '0; cm_val = '0; cm_silent = 1'b0;
    end else if (fl) begin
      rob_m.delete();
      next_tag = 1; full_m = 1'b0;
      cm_id = '0; cm_rd = '0; cm_val = '0; cm_silent = 1'b0;
    end else begin
      do_cmt = (rob_m.size() > 0) && rob_m[0].rdy;
      if (do_cmt) begin
        cm_silent = (rob_m[0].rd == 5'd0);
        cm_id     = cm_silent ? 3'd0 : rob_m[0].tag;
        cm_rd     = cm_silent ? 5'd0 : rob_m[0].rd;
        cm_val    = mval[rob_m[0].tag];
      end else begin
        cm_id = '0; cm_rd = '0; cm_val = '0; cm_silent = 1'b0;
      end
      if (wv && wid != 3'd0) begin
        k = find(wid);
        if (k >= 0) begin
          rob_m[k].rdy = 1'b1;
          mval[wid]    = wval;
        end
      end
      if (acc) begin
        rob_m.push_back('{tag: 3'(next_tag), rd: d, rdy: 1'b0});
        next_tag = (next_tag == 7) ? 1 : next_tag + 1;
      end
      if (do_cmt) void'(rob_m.pop_front());
      full_m = (rob_m.size() == 7);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    rdy = 1'b0; issue_valid = 1'b0; issue_dest = '0; wb_valid = 1'b0;
    wb_rob_id = '0; wb_value = '0; ask_rob_id1 = '0; ask_rob_id2 = '0; flush = 1'b0;
    #2;
    model_reset();
    check_eq("rst_full", 32'(rob_full), 32'h0);
    check_eq("rst_commit_id", 32'(commit_rob_id), 32'h0);
    check_eq("rst_commit_val", commit_value, 32'h0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic       r, iv, wv, fl;
    logic [4:0] d;
    logic [2:0] wid;
    do_reset();

    // First issue and its commit pulse
    cyc(1, 1, 5, 0, 0, 0, 1, 0, 0);
    check_eq("first_tag", 32'(obs_issue_id), 32'd1);
    check_eq("first_rd", 32'(obs_issue_rd), 32'd5);
    cyc(1, 0, 0, 1, 1, 32'hDEADBEEF, 0, 0, 0);
    idle(2);
    check_eq("first_commit_id", 32'(obs_cm_id), 32'd1);
    check_eq("first_commit_rd", 32'(obs_cm_rd), 32'd5);
    check_eq("first_commit_val", obs_cm_val, 32'hDEADBEEF);
    idle(1);
    check_eq("commit_one_cycle", 32'(obs_cm_id), 32'd0);

    // Fill, reject when full, wrap to tag 1
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 7; i++) begin
      cyc(1, 1, 5'(i), 0, 0, 0, 0, 0, 0);
      check_eq("fill_tag", 32'(obs_issue_id), 32'(i));
    end
    cyc(1, 1, 9, 0, 0, 0, 0, 0, 0);
    check_eq("full_flag", 32'(obs_full), 32'd1);
    check_eq("full_reject", 32'(obs_issue_id), 32'd0);
    cyc(1, 0, 0, 1, 1, 32'h1111, 0, 0, 0);
    cyc(1, 1, 9, 0, 0, 0, 0, 0, 0);
    check_eq("full_commit_reject", 32'(obs_issue_id), 32'd0);
    cyc(1, 1, 9, 0, 0, 0, 0, 0, 0);
    check_eq("wrap_tag", 32'(obs_issue_id), 32'd1);

    // Out-of-order writeback, in-order retire, query forwarding
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 1; i <= 3; i++) cyc(1, 1, 5'(i), 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 3, 32'h33, 0, 0, 0);
    cyc(1, 0, 0, 1, 2, 32'h55, 2, 5, 0);
    check_eq("fwd_ready", 32'(obs_gr1), 32'd1);
    check_eq("fwd_value", obs_gv1, 32'h55);
    check_eq("nonbusy_ready", 32'(obs_gr2), 32'd0);
    check_eq("nonbusy_value", obs_gv2, 32'd0);
    cyc(1, 0, 0, 1, 1, 32'h11, 0, 0, 0);
    seen.delete();
    idle(4);
    check_eq("ooo_c0", 32'(seen[0]), 32'd0);
    check_eq("ooo_c1", 32'(seen[1]), 32'd1);
    check_eq("ooo_c2", 32'(seen[2]), 32'd2);
    check_eq("ooo_c3", 32'(seen[3]), 32'd3);

    // rd = 0 retires silently, next entry commits normally
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 7, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 4, 32'h44, 0, 0, 0);
    cyc(1, 0, 0, 1, 5, 32'h77, 0, 0, 0);
    seen.delete();
    idle(3);
    check_eq("silent_commit", 32'(seen[0]), 32'd0);
    check_eq("after_silent", 32'(seen[1]), 32'd5);

    // Flush with four in flight plus same-cycle issue and writeback
    for (int i = 0; i < 4; i++) cyc(1, 1, 5'(i + 10), 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 1, 6, 32'h66, 0, 0, 1);
    check_eq("flush_issue_id", 32'(obs_issue_id), 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("flush_full", 32'(obs_full), 32'd0);
    check_eq("flush_commit", 32'(obs_cm_id), 32'd0);
    cyc(1, 1, 8, 0, 0, 0, 0, 0, 0);
    check_eq("flush_new_tag", 32'(obs_issue_id), 32'd1);

    // Random traffic with a mid-run reset
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      r  = ($urandom_range(0, 9) != 0);
      iv = ($urandom_range(0, 2) != 0);
      d  = 5'($urandom_range(0, 31));
      fl = ($urandom_range(0, 59) == 0);
      wv = ($urandom_range(0, 2) != 0);
      if (rob_m.size() > 0 && $urandom_range(0, 3) != 0)
        wid = rob_m[$urandom_range(0, rob_m.size() - 1)].tag;
      else
        wid = 3'($urandom_range(0, 7));
      cyc(r, iv, d, wv, wid, $urandom, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), fl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
